// File: rtl/cpu_defs.sv
// Shared CPU-side definitions for the joypad block: the P1 select encoding,
// the register address, the interrupt bit and the default timing constants.
package cpu_defs;

    // Select bits [5:4] of the joypad register; a 0 enables that group.
    typedef enum logic [1:0] {
        SEL_BOTH = 2'b00,
        SEL_FACE = 2'b01,
        SEL_DPAD = 2'b10,
        SEL_NONE = 2'b11
    } joyp_sel_t;

    localparam logic [15:0] JOYP_ADDR           = 16'hFF00;
    localparam int          JOYP_IRQ_BIT        = 4;
    localparam int          JOYP_TICK_DIV       = 4096;
    localparam int          JOYP_STABLE_SAMPLES = 4;

    // Nibble the CPU sees for a given select; buttons are active-low, so
    // selecting both groups ANDs them (a press in either group reads 0).
    function automatic logic [3:0] joyp_nibble(input joyp_sel_t sel, input logic [7:0] keys);
        logic [3:0] nib;
        case (sel)
            SEL_DPAD: nib = keys[3:0];
            SEL_FACE: nib = keys[7:4];
            SEL_BOTH: nib = keys[3:0] & keys[7:4];
            default:  nib = 4'hF;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/joypad_ctrl_m_if.sv
// Signal bundle between the joypad pins/CPU side and the joypad controller.
// There is no handshake on this bundle: every signal is level-sensitive and
// sampled on each rising clk; irq_pulse and tick_out are single-cycle strobes.
interface joypad_ctrl_m_if;
    logic [7:0] je_raw;     // asynchronous active-low button pins
    logic [1:0] sel;        // joypad register select bits [5:4]
    logic [7:0] je_clean;   // debounced active-low buttons
    logic       irq_pulse;  // one-cycle joypad interrupt request
    logic       tick_out;   // debounce sample-tick strobe

    modport master (
        output je_raw,
        output sel,
        input  je_clean,
        input  irq_pulse,
        input  tick_out
    );

    modport slave (
        input  je_raw,
        input  sel,
        output je_clean,
        output irq_pulse,
        output tick_out
    );
endinterface

// File: rtl/joypad_debounce_bit_m.sv
// One button: two-flop synchronizer, tick-sampled history and level
// acceptance. The cleaned level only moves when the whole history agrees.
module joypad_debounce_bit_m #(
    parameter int STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    input  logic tick_i,
    output logic clean_o
);

    logic                      sync1_q;
    logic                      sync2_q;
    logic [STABLE_SAMPLES-1:0] hist_q;
    logic [STABLE_SAMPLES-1:0] hist_d;
    logic                      clean_q;
    logic                      clean_d;

    // Shift the synchronized level in on a tick and accept a unanimous history.
    always_comb begin
        hist_d  = hist_q;
        clean_d = clean_q;
        if (tick_i) begin
            hist_d = {hist_q[STABLE_SAMPLES-2:0], sync2_q};
            if ((hist_d == '1) && !clean_q) begin
                clean_d = 1'b1;
            end else if ((hist_d == '0) && clean_q) begin
                clean_d = 1'b0;
            end
        end
    end

    // Synchronizer, history and clean level; reset looks like a released button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= '1;
            clean_q <= 1'b1;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o = clean_q;

endmodule

// File: rtl/joypad_ctrl_m.sv
// Joypad controller: sample-tick prescaler, eight debounced buttons, nibble
// selection and the press-edge interrupt request.
module joypad_ctrl_m
    import cpu_defs::*;
#(
    parameter int TICK_DIV       = JOYP_TICK_DIV,
    parameter int STABLE_SAMPLES = JOYP_STABLE_SAMPLES
) (
    input logic             clk,
    input logic             rst,
    joypad_ctrl_m_if.slave  bus
);

    localparam int             CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;
    logic [7:0]       clean;
    logic [7:0]       prev_q;
    logic             irq_q;
    logic             irq_d;
    logic [3:0]       fall;
    joyp_sel_t        sel_e;

    // Prescaler wraps at TICK_DIV-1; the tick is masked while reset is held.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    assign tick = (cnt_q == CNT_LAST) && !rst;

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Eight identical debouncers sharing one sample tick.
    for (genvar g = 0; g < 8; g++) begin : g_bit
        joypad_debounce_bit_m #(
            .STABLE_SAMPLES (STABLE_SAMPLES)
        ) u_bit (
            .clk     (clk),
            .rst     (rst),
            .raw_i   (bus.je_raw[g]),
            .tick_i  (tick),
            .clean_o (clean[g])
        );
    end

    // A selected bit falling between the previous and current clean value is a
    // press; prev_q tracks clean every cycle so a sel change alone never fires.
    always_comb begin
        sel_e = joyp_sel_t'(bus.sel);
        fall  = joyp_nibble(sel_e, prev_q) & ~joyp_nibble(sel_e, clean);
        irq_d = (|fall) && !irq_q;
    end

    // Previous clean snapshot and registered interrupt strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 8'hFF;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= clean;
            irq_q  <= irq_d;
        end
    end

    assign bus.je_clean  = clean;
    assign bus.irq_pulse = irq_q;
    assign bus.tick_out  = tick;

endmodule
